// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU-bus register front end for one uart_tx / uart_rx pair.
// Define UART_CTRL_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise a single-byte RX buffer.
`default_nettype none

module uart_ctrl #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [7:0]  wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        irq_o,
  input  logic        rx_end_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_end_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, ACTIVE = 2'd2} tx_state_e;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_DATA   = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_ctrl: RX_DEPTH must be a power of two >= 2");
  end

  tx_state_e   state_q, state_d;
  logic        ack_q, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rx_ovr_q, rx_ovr_d, tx_ovr_q, tx_ovr_d;
  logic        rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
  logic [7:0]  hold_q, hold_d, tx_data_q, tx_data_d;
  logic        hold_full_q, hold_full_d;
  logic        load_tx, tx_busy;
  logic        rx_valid, rx_full, pop, push, rx_ovr_set;
  logic [7:0]  rx_head;

  assign pop        = req_i && !we_i && (addr_i == A_DATA) && rx_valid;
  assign push       = rx_end_i && (!rx_full || pop);
  assign rx_ovr_set = rx_end_i && rx_full && !pop;

`ifdef UART_CTRL_RX_FIFO_EN
  localparam int AW = $clog2(RX_DEPTH);
  logic [7:0]  mem_q [RX_DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  assign rx_valid = (wptr_q != rptr_q);
  assign rx_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rx_head  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // When full, a simultaneous pop frees exactly the slot the push lands in.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= rx_data_i;
  end
`else
  logic [7:0] rx_buf_q;
  logic       rx_vld_q;

  assign rx_valid = rx_vld_q;
  assign rx_full  = rx_vld_q;
  assign rx_head  = rx_buf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_buf_q <= '0;
      rx_vld_q <= 1'b0;
    end else begin
      if (push) rx_buf_q <= rx_data_i;
      if (push)     rx_vld_q <= 1'b1;
      else if (pop) rx_vld_q <= 1'b0;
    end
  end
`endif

  assign tx_busy = hold_full_q || (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    load_tx = 1'b0;
    unique case (state_q)
      IDLE:    if (hold_full_q) begin
                 state_d = START;
                 load_tx = 1'b1;
               end
      START:   state_d = ACTIVE;
      ACTIVE:  if (tx_end_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d     = '0;
    rx_ovr_d    = rx_ovr_q;
    tx_ovr_d    = tx_ovr_q;
    rx_ie_d     = rx_ie_q;
    tx_ie_d     = tx_ie_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q && !load_tx;
    tx_data_d   = load_tx ? hold_q : tx_data_q;
    irq_d       = (rx_ie_q && rx_valid) || (tx_ie_q && !tx_busy);
    if (req_i && !we_i) begin
      unique case (addr_i)
        A_STATUS: rdata_d = {28'd0, tx_ovr_q, rx_ovr_q, tx_busy, rx_valid};
        A_DATA:   rdata_d = rx_valid ? {24'd0, rx_head} : 32'd0;
        A_CTRL:   rdata_d = {30'd0, tx_ie_q, rx_ie_q};
        default:  rdata_d = '0;
      endcase
    end
    if (req_i && we_i) begin
      unique case (addr_i)
        A_STATUS: begin
          if (wdata_i[2]) rx_ovr_d = 1'b0;
          if (wdata_i[3]) tx_ovr_d = 1'b0;
        end
        A_DATA: begin
          // Hold counts as full even in the cycle it is handed to the FSM.
          if (hold_full_q) tx_ovr_d = 1'b1;
          else begin
            hold_d      = wdata_i;
            hold_full_d = 1'b1;
          end
        end
        A_CTRL: begin
          rx_ie_d = wdata_i[0];
          tx_ie_d = wdata_i[1];
        end
        default: ;
      endcase
    end
    if (rx_ovr_set) rx_ovr_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_ovr_q    <= 1'b0;
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= req_i;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_ovr_q    <= tx_ovr_d;
      rx_ie_q     <= rx_ie_d;
      tx_ie_q     <= tx_ie_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign ack_o      = ack_q;
  assign rdata_o    = rdata_q;
  assign irq_o      = irq_q;
  assign tx_start_o = (state_q == START);
  assign tx_data_o  = tx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed test-plan sequences plus random traffic, checked against a
// queue-based reference model of the register/FIFO/transmit rules.
`default_nettype none

module tb_uart_ctrl;
  localparam int RX_DEPTH = 4;
`ifdef UART_CTRL_RX_FIFO_EN
  localparam int CAP = RX_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic        clk, rst_n, req, we, rx_end, tx_end;
  logic [1:0]  addr;
  logic [7:0]  wdata, rx_data;
  logic [31:0] rdata;
  logic        ack, irq, tx_start;
  logic [7:0]  tx_data;

  uart_ctrl #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .irq_o(irq),
    .rx_end_i(rx_end), .rx_data_i(rx_data), .tx_start_o(tx_start),
    .tx_data_o(tx_data), .tx_end_i(tx_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: RX buffer as a bounded queue, transmitter as a phase number
  // (0 idle, 1 start pulse, 2 serial core busy).
  logic [7:0]  rxq[$];
  logic        m_rx_ovr, m_tx_ovr, m_rx_ie, m_tx_ie, m_hold_v;
  logic [7:0]  m_hold, m_tx_byte;
  int          m_phase;
  logic        e_ack, e_irq;
  logic [31:0] e_rdata;

  task automatic model_reset();
    rxq.delete();
    m_rx_ovr = 0; m_tx_ovr = 0; m_rx_ie = 0; m_tx_ie = 0; m_hold_v = 0;
    m_hold = 0; m_tx_byte = 0; m_phase = 0;
    e_ack = 0; e_irq = 0; e_rdata = 0;
  endtask

  task automatic model_step(input logic rq, input logic w, input logic [1:0] a,
                            input logic [7:0] wd, input logic re, input logic [7:0] rd,
                            input logic te);
    logic busy, full, pop, rx_set, clr_rx, clr_tx, tx_set, hold_was;
    busy = m_hold_v || (m_phase != 0);
    full = (rxq.size() == CAP);
    pop = 0; clr_rx = 0; clr_tx = 0; tx_set = 0;
    e_irq   = (m_rx_ie && rxq.size() != 0) || (m_tx_ie && !busy);
    e_ack   = rq;
    e_rdata = 0;
    if (rq && !w) begin
      if (a == 0) e_rdata = {28'd0, m_tx_ovr, m_rx_ovr, busy, rxq.size() != 0};
      else if (a == 1 && rxq.size() != 0) begin
        e_rdata = {24'd0, rxq[0]};
        pop = 1;
      end else if (a == 2) e_rdata = {30'd0, m_tx_ie, m_rx_ie};
    end
    hold_was = m_hold_v;
    if (m_phase == 0 && m_hold_v) begin
      m_tx_byte = m_hold; m_hold_v = 0; m_phase = 1;
    end else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2 && te) m_phase = 0;
    if (rq && w) begin
      if (a == 0) begin clr_rx = wd[2]; clr_tx = wd[3]; end
      else if (a == 1) begin
        if (hold_was) tx_set = 1;
        else begin m_hold = wd; m_hold_v = 1; end
      end else if (a == 2) begin m_rx_ie = wd[0]; m_tx_ie = wd[1]; end
    end
    rx_set = re && full && !pop;
    if (pop) void'(rxq.pop_front());
    if (re && !rx_set) rxq.push_back(rd);
    m_rx_ovr = (m_rx_ovr && !clr_rx) || rx_set;
    m_tx_ovr = (m_tx_ovr && !clr_tx) || tx_set;
  endtask

  // One bus cycle: check outputs of the previous edge, drive new inputs, advance model.
  task automatic cycle(input logic rq, input logic w, input logic [1:0] a, input logic [7:0] wd,
                       input logic re, input logic [7:0] rd, input logic te);
    @(negedge clk);
    check("ack", ack, e_ack);
    check("rdata", rdata, e_rdata);
    check("irq", irq, e_irq);
    check("tx_start", tx_start, m_phase == 1);
    check("tx_data", tx_data, m_tx_byte);
    req = rq; we = w; addr = a; wdata = wd; rx_end = re; rx_data = rd; tx_end = te;
    model_step(rq, w, a, wd, re, rd, te);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d); cycle(1, 1, a, d, 0, 0, 0); endtask
  task automatic rd(input logic [1:0] a);                      cycle(1, 0, a, 0, 0, 0, 0); endtask
  task automatic inj(input logic [7:0] d);                     cycle(0, 0, 0, 0, 1, d, 0); endtask
  task automatic txend();                                      cycle(0, 0, 0, 0, 0, 0, 1); endtask
  task automatic peek(input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    rst_n = 0; req = 0; we = 0; addr = 0; wdata = 0; rx_end = 0; rx_data = 0; tx_end = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_tx_start", tx_start, 0);
    rst_n = 1;

    // Transmit path: 0x5A, then 0xA5 queued behind it, then hold overrun.
    wr(1, 8'h5A);
    idle(1);
    @(posedge clk); #1;
    check("tp_tx_start", tx_start, 1);
    check("tp_tx_data", tx_data, 8'h5A);
    idle(3);
    wr(1, 8'hA5);
    idle(5);
    txend();
    idle(4);
    wr(1, 8'hC3);
    wr(1, 8'h3C);
    rd(0);
    peek("tp_status_ovr", 32'h0A);
    wr(0, 8'h08);
    rd(0);
    peek("tp_status_clr", 32'h02);
    txend();
    idle(4);

    // Reset in the middle of a transmission abandons it.
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    check("async_tx_start", tx_start, 0);
    check("async_tx_data", tx_data, 0);
    check("async_irq", irq, 0);
    @(negedge clk);
    rst_n = 1;
    rd(0);
    peek("rst_status", 32'h0);
    txend();

    // RX ordering, empty read, overrun, full with simultaneous pop and push.
    inj(8'h11); inj(8'h22); inj(8'h33); inj(8'h44);
    rd(1);
    peek("rx_first", 32'h11);
    for (int i = 0; i < 4; i++) rd(1);
    rd(0);
    for (int i = 0; i < CAP; i++) inj(8'(8'h10 + i));
    inj(8'h55);
    rd(0);
    cycle(1, 0, 1, 0, 1, 8'h66, 0);
    rd(0);
    for (int i = 0; i < CAP + 1; i++) rd(1);
    wr(0, 8'h0C);

    // Interrupts.
    wr(2, 8'h01);
    inj(8'h9C);
    idle(3);
    rd(1);
    idle(3);
    wr(2, 8'h02);
    idle(3);
    wr(1, 8'h42);
    idle(6);
    txend();
    idle(4);
    wr(2, 8'h00);

    // Single-byte style: second byte without a read.
    inj(8'h77); inj(8'h88);
    rd(1);
    peek("rx_77", 32'h77);
    rd(0);
    for (int i = 0; i < CAP; i++) rd(1);
    wr(0, 8'h0C);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rq, w, re, te;
      rq = ($urandom_range(0, 2) == 0);
      w  = $urandom_range(0, 1);
      re = ($urandom_range(0, 3) == 0);
      te = ($urandom_range(0, 4) == 0);
      cycle(rq, w, 2'($urandom_range(0, 3)), 8'($urandom), re, 8'($urandom), te);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
